// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART core.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    function automatic int default_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one-clock tick every D clocks, D = baud_div or default.
module uart_baud_gen #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] div_last;
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // >= rather than == so a shrinking divisor cannot strand the counter
    always_comb begin
        div_eff  = (baud_div == '0) ? DIV_W'(DEFAULT_DIV) : baud_div;
        div_last = div_eff - ONE;
        tick     = (cnt_q == div_last);
        cnt_d    = (cnt_q >= div_last) ? '0 : cnt_q + ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_core.sv
// UART core: oversampling RX and TX with valid/ready handshakes.
// Define UART_PARITY_EN to add a parity bit (parity_odd selects odd).
module uart_core
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             parity_odd,
    input  logic             rx,
    output logic [DBIT-1:0]  rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_frame_err,
    output logic             rx_parity_err,
    output logic             rx_overrun,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [DBIT-1:0]  tx_data,
    output logic             tx,
    output logic             tx_done
);

    localparam int DEFAULT_DIV = default_div(CLOCK_FREQ, BAUD, OVERSAMPLE);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DBIT);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DBIT - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    logic tick;

    uart_baud_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_div (baud_div),
        .tick     (tick)
    );

    logic [1:0]       sync_q;
    logic             rx_s;
    rx_state_e        rx_state_q, rx_state_d;
    logic [OS_W-1:0]  rx_os_q, rx_os_d;
    logic [BIT_W-1:0] rx_bit_q, rx_bit_d;
    logic [DBIT-1:0]  rx_sh_q, rx_sh_d;
    logic             rx_arm_q, rx_arm_d;
    logic [DBIT-1:0]  rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ferr_q, rx_ferr_d;
    logic             rx_perr_q, rx_perr_d;
    logic             rx_ovr_q, rx_ovr_d;
    logic             rx_end;
    logic             frame_perr;

    tx_state_e        tx_state_q, tx_state_d;
    logic [OS_W-1:0]  tx_os_q, tx_os_d;
    logic [BIT_W-1:0] tx_bit_q, tx_bit_d;
    logic [DBIT-1:0]  tx_sh_q, tx_sh_d;
    logic             tx_go_q, tx_go_d;
    logic             tx_q, tx_d;
    logic             tx_done_q, tx_done_d;

`ifdef UART_PARITY_EN
    logic rx_pchk_q, rx_pchk_d;
    logic tx_par_q, tx_par_d;
    assign frame_perr = rx_pchk_q;
`else
    logic unused_parity;
    assign unused_parity = parity_odd;
    assign frame_perr    = 1'b0;
`endif

    assign rx_s = sync_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_os_d    = rx_os_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_arm_d   = rx_arm_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_ferr_d  = rx_ferr_q;
        rx_perr_d  = rx_perr_q;
        rx_ovr_d   = 1'b0;
        rx_end     = 1'b0;
`ifdef UART_PARITY_EN
        rx_pchk_d  = rx_pchk_q;
`endif
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
            rx_ferr_d  = 1'b0;
            rx_perr_d  = 1'b0;
        end
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_os_d  = '0;
                rx_bit_d = '0;
`ifdef UART_PARITY_EN
                rx_pchk_d = 1'b0;
`endif
                // a held-low line (break) must go high before re-arming
                if (rx_s)          rx_arm_d   = 1'b1;
                else if (rx_arm_q) rx_state_d = RX_START;
            end
            RX_START: if (tick) begin
                if (rx_os_q == OS_MID) begin
                    rx_os_d    = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_os_d = rx_os_q + OS_ONE;
                end
            end
            RX_DATA: if (tick) begin
                if (rx_os_q == OS_LAST) begin
                    rx_os_d  = '0;
                    rx_sh_d  = {rx_s, rx_sh_q[DBIT-1:1]};
                    rx_bit_d = rx_bit_q + BIT_ONE;
                    if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end
                end else begin
                    rx_os_d = rx_os_q + OS_ONE;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (tick) begin
                if (rx_os_q == OS_LAST) begin
                    rx_os_d    = '0;
                    rx_pchk_d  = rx_s ^ (^rx_sh_q) ^ parity_odd;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_os_d = rx_os_q + OS_ONE;
                end
            end
`endif
            RX_STOP: if (tick) begin
                if (rx_os_q == OS_LAST) begin
                    rx_os_d    = '0;
                    rx_end     = 1'b1;
                    rx_state_d = RX_IDLE;
                    if (!rx_s) rx_arm_d = 1'b0;
                end else begin
                    rx_os_d = rx_os_q + OS_ONE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
        if (rx_end) begin
            if (rx_valid_q) begin
                rx_ovr_d = 1'b1;
            end else begin
                rx_data_d  = rx_sh_q;
                rx_ferr_d  = ~rx_s;
                rx_perr_d  = frame_perr;
                rx_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_os_d    = tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_go_d    = tx_go_q;
        tx_done_d  = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        unique case (tx_state_q)
            TX_IDLE: if (tx_valid) begin
                tx_sh_d    = tx_data;
                tx_os_d    = '0;
                tx_bit_d   = '0;
                tx_go_d    = 1'b0;
`ifdef UART_PARITY_EN
                tx_par_d   = (^tx_data) ^ parity_odd;
`endif
                tx_state_d = TX_START;
            end
            TX_START: if (tick) begin
                // line stays high until the first tick after acceptance
                if (!tx_go_q) begin
                    tx_go_d = 1'b1;
                    tx_os_d = '0;
                end else if (tx_os_q == OS_LAST) begin
                    tx_os_d    = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_os_d = tx_os_q + OS_ONE;
                end
            end
            TX_DATA: if (tick) begin
                if (tx_os_q == OS_LAST) begin
                    tx_os_d  = '0;
                    tx_sh_d  = {1'b0, tx_sh_q[DBIT-1:1]};
                    tx_bit_d = tx_bit_q + BIT_ONE;
                    if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
`else
                        tx_state_d = TX_STOP;
`endif
                    end
                end else begin
                    tx_os_d = tx_os_q + OS_ONE;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: if (tick) begin
                if (tx_os_q == OS_LAST) begin
                    tx_os_d    = '0;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_os_d = tx_os_q + OS_ONE;
                end
            end
`endif
            TX_STOP: if (tick) begin
                if (tx_os_q == OS_LAST) begin
                    tx_os_d    = '0;
                    tx_done_d  = 1'b1;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_os_d = tx_os_q + OS_ONE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        unique case (tx_state_d)
            TX_START:  tx_d = ~tx_go_d;
            TX_DATA:   tx_d = tx_sh_d[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_d = tx_par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_os_q    <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_arm_q   <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_go_q    <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx};
            rx_state_q <= rx_state_d;
            rx_os_q    <= rx_os_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_arm_q   <= rx_arm_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_perr_q  <= rx_perr_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_state_q <= tx_state_d;
            tx_os_q    <= tx_os_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_go_q    <= tx_go_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_pchk_q <= 1'b0;
            tx_par_q  <= 1'b0;
        end else begin
            rx_pchk_q <= rx_pchk_d;
            tx_par_q  <= tx_par_d;
        end
    end
`endif

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_overrun    = rx_ovr_q;
    assign tx_ready      = (tx_state_q == TX_IDLE);
    assign tx            = tx_q;
    assign tx_done       = tx_done_q;

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: queued expectations, decoupled RX/TX monitors.
`timescale 1ns/1ps
module tb_uart_core;

    localparam int DBIT = 8;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } rx_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        parity_odd;
    logic        rx;
    logic        rx_drv;
    logic        loop_en;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_frame_err;
    logic        rx_parity_err;
    logic        rx_overrun;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx;
    logic        tx_done;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int done_cnt = 0;
    int bit_clks = 64;
    logic tx_mon_en = 1'b1;

    rx_exp_t    rx_exp[$];
    logic [7:0] tx_exp[$];
    rx_exp_t    rx_e;

    assign rx = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_core #(
        .CLOCK_FREQ (50_000_000),
        .BAUD       (115200),
        .DBIT       (DBIT),
        .OVERSAMPLE (16),
        .DIV_W      (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .baud_div      (baud_div),
        .parity_odd    (parity_odd),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_overrun    (rx_overrun),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx            (tx),
        .tx_done       (tx_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=missing required=present", name);
    endtask

    function automatic rx_exp_t mk(input logic [7:0] d, input logic fe, input logic pe);
        mk = {d, fe, pe};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_send(input logic [7:0] d);
        int i;
        i = 0;
        while (!tx_ready && i < 20000) begin
            step(1);
            i++;
        end
        if (!tx_ready) fail("tx_ready_timeout");
        tx_data  = d;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop, input logic pflip);
        rx_drv = 1'b0;
        step(bit_clks);
        for (int i = 0; i < DBIT; i++) begin
            rx_drv = d[i];
            step(bit_clks);
        end
`ifdef UART_PARITY_EN
        rx_drv = (^d) ^ parity_odd ^ pflip;
        step(bit_clks);
`endif
        rx_drv = stop;
        step(bit_clks);
        rx_drv = 1'b1;
        step(bit_clks);
    endtask

    task automatic wait_drain(input int max);
        for (int i = 0; i < max && (rx_exp.size() != 0 || tx_exp.size() != 0); i++)
            step(1);
        if (rx_exp.size() != 0 || tx_exp.size() != 0) fail("drain_timeout");
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rx_valid && rx_ready) begin
            if (rx_exp.size() == 0) begin
                fail("rx_unexpected_word");
            end else begin
                rx_e = rx_exp.pop_front();
                chk("rx_word", {rx_data, rx_frame_err, rx_parity_err}, rx_e);
            end
        end
        if (rx_overrun) ovr_cnt++;
        if (tx_done) begin
            done_cnt++;
            chk("tx_done_ready", tx_ready, 1'b1);
        end
    end

    initial begin
        logic          prev;
        logic [NB-1:0] early, late, expv;
        logic [7:0]    d;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_mon_en && prev && !tx) begin
                for (int c = 1; c <= NB * bit_clks - 2; c++) begin
                    @(negedge clk);
                    if (c % bit_clks == 2)            early[c / bit_clks] = tx;
                    if (c % bit_clks == bit_clks - 2) late[c / bit_clks]  = tx;
                end
                if (tx_exp.size() == 0) begin
                    fail("tx_unexpected_frame");
                end else begin
                    d = tx_exp.pop_front();
`ifdef UART_PARITY_EN
                    expv = {1'b1, (^d) ^ parity_odd, d, 1'b0};
`else
                    expv = {1'b1, d, 1'b0};
`endif
                    chk("tx_frame_early", early, expv);
                    chk("tx_frame_late", late, expv);
                end
            end
            prev = tx;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] words [3];
        words[0] = 8'h00;
        words[1] = 8'hFF;
        words[2] = 8'h3C;
        rst_n      = 1'b0;
        baud_div   = 16'd4;
        parity_odd = 1'b0;
        rx_drv     = 1'b1;
        loop_en    = 1'b0;
        rx_ready   = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        bit_clks   = 64;
        step(3);
        chk("reset_tx", tx, 1'b1);
        chk("reset_tx_ready", tx_ready, 1'b1);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_flags", {rx_frame_err, rx_parity_err, rx_overrun, tx_done}, 4'b0000);
        rst_n = 1'b1;
        step(4);

        done_cnt = 0;
        tx_exp.push_back(8'hA5);
        tx_send(8'hA5);
        wait_drain(2000);
        step(10);
        chk("tx_done_count_a5", done_cnt, 1);

        baud_div = 16'd0;
        bit_clks = 432;
        loop_en  = 1'b1;
        step(40);
        foreach (words[i]) begin
            tx_exp.push_back(words[i]);
            rx_exp.push_back(mk(words[i], 1'b0, 1'b0));
            tx_send(words[i]);
        end
        wait_drain(20000);
        step(600);
        loop_en  = 1'b0;
        baud_div = 16'd4;
        bit_clks = 64;
        step(40);

        rx_drv = 1'b0;
        step(12);
        rx_drv = 1'b1;
        step(200);
        chk("glitch_no_valid", rx_valid, 1'b0);
        rx_exp.push_back(mk(8'h55, 1'b0, 1'b0));
        send_rx(8'h55, 1'b1, 1'b0);
        wait_drain(2000);

        rx_ready = 1'b0;
        ovr_cnt  = 0;
        rx_exp.push_back(mk(8'h11, 1'b0, 1'b0));
        send_rx(8'h11, 1'b1, 1'b0);
        send_rx(8'h22, 1'b1, 1'b0);
        step(20);
        chk("overrun_count", ovr_cnt, 1);
        chk("overrun_valid_held", rx_valid, 1'b1);
        chk("overrun_data_held", rx_data, 8'h11);
        rx_ready = 1'b1;
        wait_drain(200);

        rx_exp.push_back(mk(8'h7E, 1'b1, 1'b0));
        send_rx(8'h7E, 1'b0, 1'b0);
        wait_drain(2000);

`ifdef UART_PARITY_EN
        parity_odd = 1'b0;
        rx_exp.push_back(mk(8'h03, 1'b0, 1'b1));
        send_rx(8'h03, 1'b1, 1'b1);
        wait_drain(2000);
`endif

        tx_mon_en = 1'b0;
        tx_send(8'hC3);
        step(200);
        rst_n = 1'b0;
        #1;
        chk("midreset_tx", tx, 1'b1);
        chk("midreset_tx_ready", tx_ready, 1'b1);
        chk("midreset_tx_done", tx_done, 1'b0);
        step(4);
        rst_n = 1'b1;
        step(4);
        tx_mon_en = 1'b1;
        done_cnt  = 0;
        tx_exp.push_back(8'h81);
        tx_send(8'h81);
        wait_drain(2000);
        step(10);
        chk("tx_done_count_81", done_cnt, 1);

        step(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 The module SHALL have parameter CLOCK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD, default 115200, baud rate used when baud_div is 0.
REQ-003 The module SHALL have parameter DBIT, default 8, data bits per frame (5..9).
REQ-004 The module SHALL have parameter OVERSAMPLE, default 16, baud ticks per bit (even, >=8).
REQ-005 The module SHALL have parameter DIV_W, default 16, width of the runtime divisor.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have port baud_div, input, DIV_W bits: clocks per baud tick; 0 selects DEFAULT_DIV = CLOCK_FREQ/(BAUD*OVERSAMPLE), truncated.
REQ-009 The module SHALL have port parity_odd, input, 1 bit: 1 selects odd parity, 0 selects even; ignored without UART_PARITY_EN.
REQ-010 The module SHALL have port rx, input, 1 bit: asynchronous serial input.
REQ-011 The module SHALL have port rx_data, output, DBIT bits: received word.
REQ-012 The module SHALL have ports rx_valid (output, 1 bit) and rx_ready (input, 1 bit): receive handshake.
REQ-013 The module SHALL have ports rx_frame_err, rx_parity_err and rx_overrun, each output, 1 bit: receive status.
REQ-014 The module SHALL have ports tx_valid (input, 1 bit), tx_ready (output, 1 bit) and tx_data (input, DBIT bits): transmit handshake.
REQ-015 The module SHALL have ports tx (output, 1 bit): serial output, and tx_done (output, 1 bit): one-cycle pulse at end of frame.

Function
REQ-016 Baud gen SHALL count 0..D-1 (D = effective divisor) and pulse tick for 1 clk when count==D-1; if count>=D-1 after a divisor change, it SHALL wrap to 0 on the next clk.
REQ-017 rx SHALL pass through a 2-FF synchronizer; all RX decisions SHALL use the synchronized value.
REQ-018 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; IDLE->START on synced rx==0, tick counter cleared.
REQ-019 In START, at tick OVERSAMPLE/2-1: rx==0 -> DATA; rx==1 -> IDLE (glitch rejected, no output).
REQ-020 DATA SHALL sample once every OVERSAMPLE ticks, LSB first, DBIT bits, then go to PARITY (macro defined) or STOP.
REQ-021 STOP SHALL sample after OVERSAMPLE ticks; rx==0 sets frame error; the FSM then returns to IDLE even when rx is held low (a break reports one errored word).
REQ-022 On STOP completion with rx_valid==0: rx_data, rx_frame_err and rx_parity_err SHALL load, and rx_valid SHALL assert on the next clk.
REQ-023 rx_valid SHALL hold until the clk where rx_valid&&rx_ready; it clears on that clk, and the error flags clear with it.
REQ-024 If a frame completes while rx_valid==1, the new word SHALL be discarded, held data SHALL be unchanged, and rx_overrun SHALL pulse for 1 clk.
REQ-025 tx_ready SHALL be 1 only in TX IDLE; tx_valid&&tx_ready SHALL latch tx_data and drop tx_ready on the next clk.
REQ-026 TX FSM (IDLE, START, DATA, PARITY, STOP) SHALL drive start(0), DBIT data bits LSB first, [parity], and stop(1), each lasting exactly OVERSAMPLE ticks; start SHALL begin at the first tick after acceptance.
REQ-027 At the end of stop, tx_done SHALL pulse for 1 clk and tx_ready SHALL be 1 on that same clk; a back-to-back request SHALL be accepted on that clk.
REQ-028 tx SHALL be 1 whenever TX is IDLE.
REQ-029 A baud_div change mid-frame SHALL take effect at the next tick boundary; the team does not guarantee integrity of that frame.

Reset
REQ-030 rst_n low SHALL immediately force both FSMs to IDLE, the baud counter to 0, tx=1, tx_ready=1, and rx_data, rx_valid, all error flags, rx_overrun and tx_done to 0; a frame in flight SHALL be abandoned without output.

Configuration
REQ-031 With UART_PARITY_EN defined, both FSMs SHALL include the PARITY state: TX sends the even/odd parity bit per parity_odd, and RX sets rx_parity_err on mismatch.
REQ-032 Without UART_PARITY_EN, the PARITY state and parity_odd logic SHALL be absent, and rx_parity_err SHALL be tied to 0.

Structure
REQ-033 Package uart_pkg SHALL hold the RX/TX state enum typedefs and the DEFAULT_DIV computation function.
REQ-034 The baud generator SHALL be sub-module uart_baud_gen; RX and TX SHALL be inline in uart_core.

Verification (bench uses CLOCK_FREQ=50e6, BAUD=115200, OVERSAMPLE=16; DEFAULT_DIV=27)
REQ-035 baud_div=4, TX 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 (start, 10100101 LSB first, stop), each bit 64 clk; tx_done pulses once.
REQ-036 Loopback with baud_div=0, words 0x00, 0xFF, 0x3C -> each received with bit period 432 clk, no errors.
REQ-037 rx low pulse of 3 ticks in IDLE -> no rx_valid; next valid frame 0x55 received correctly.
REQ-038 rx_ready=0, two frames 0x11 then 0x22 -> rx_data=0x11, rx_overrun pulses once, rx_valid stays 1.
REQ-039 Stop bit forced 0 on 0x7E -> rx_valid with rx_frame_err=1; with UART_PARITY_EN and parity_odd=0, a flipped parity bit on 0x03 -> rx_parity_err=1.
REQ-040 rst_n asserted mid-TX of 0xC3 -> tx=1 and tx_ready=1 immediately; after release, a new 0x81 transmits intact.
